// File: rtl/wptr_full_level.sv
`default_nettype none
// ============================================================================
// Module   : wptr_full_level
// Purpose  : Write-clock-domain pointer and status block of the async FIFO.
//            Holds the binary and Gray write pointers and produces registered
//            full and almost-full flags plus a registered fill level, from the
//            read pointer already synchronised into wclk.
// Ports    : wclk, wrst_n (async, active-low)  - clock / reset
//            winc                              - write request
//            wq2_rptr[ADDRSIZE:0]              - synchronised Gray read ptr
//            wen                               - memory write enable (comb)
//            waddr[ADDRSIZE-1:0]               - memory write address
//            wptr[ADDRSIZE:0]                  - registered Gray write ptr
//            wfull, wafull                     - registered full / almost-full
//            wlevel[ADDRSIZE:0]                - registered fill level 0..DEPTH
//            wovf_clr, wovf                    - sticky overflow (optional)
// Options  : define WPTR_OVF_EN to add the sticky overflow flag and its clear.
// Revision : 1.0 - initial release
// ============================================================================
module wptr_full_level #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 2**ADDRSIZE - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
`ifdef WPTR_OVF_EN
  input  logic                wovf_clr,
  output logic                wovf,
`endif
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel
);

  localparam logic [ADDRSIZE:0] c_afull_thresh = (ADDRSIZE+1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] r_wbin;
  logic [ADDRSIZE:0] r_wptr;
  logic [ADDRSIZE:0] r_wlevel;
  logic              r_wfull;
  logic              r_wafull;

  logic [ADDRSIZE:0] w_wbinnext;
  logic [ADDRSIZE:0] w_wgraynext;
  logic [ADDRSIZE:0] w_rbin;
  logic [ADDRSIZE:0] w_level_next;
  logic              w_wfull_next;
  logic              w_wafull_next;

  // Writes while full are dropped here, so the pointer never overruns.
  assign wen = winc & ~r_wfull;

  assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, wen};
  assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_gray2bin
    assign w_rbin[i] = ^wq2_rptr[ADDRSIZE:i];
  end

  // Modulo 2**(ADDRSIZE+1) difference; the read pointer lags, so this can
  // only over-estimate the true occupancy.
  assign w_level_next = w_wbinnext - w_rbin;

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer: in Gray code that means the two MSBs differ and the rest match.
  assign w_wfull_next  = (w_wgraynext ==
                          {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
  assign w_wafull_next = (w_level_next >= c_afull_thresh);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin   <= '0;
      r_wptr   <= '0;
      r_wlevel <= '0;
      r_wfull  <= 1'b0;
      r_wafull <= 1'b0;
    end else begin
      r_wbin   <= w_wbinnext;
      r_wptr   <= w_wgraynext;
      r_wlevel <= w_level_next;
      r_wfull  <= w_wfull_next;
      r_wafull <= w_wafull_next;
    end
  end

  assign waddr  = r_wbin[ADDRSIZE-1:0];
  assign wptr   = r_wptr;
  assign wfull  = r_wfull;
  assign wafull = r_wafull;
  assign wlevel = r_wlevel;

`ifdef WPTR_OVF_EN
  logic r_wovf;

  // Set has priority over clear so an overflow in the clearing cycle is kept.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wovf <= 1'b0;
    end else if (winc && r_wfull) begin
      r_wovf <= 1'b1;
    end else if (wovf_clr) begin
      r_wovf <= 1'b0;
    end
  end

  assign wovf = r_wovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_level.sv
`default_nettype none
// ============================================================================
// Module   : tb_wptr_full_level
// Purpose  : Self-checking bench for wptr_full_level (ADDRSIZE=4, threshold 14).
//            Vector tables and hand sequences push expected records into a
//            queue; each record is popped and compared after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wptr_full_level;

  localparam int ADDRSIZE     = 4;
  localparam int DEPTH        = 16;
  localparam int AFULL_THRESH = 14;

  typedef struct {
    logic winc;
    int   rd;      // read count presented (Gray-coded) on wq2_rptr
    logic clr;
    logic wen;     // expected wen before the edge
    int   wbin;    // expected binary write count after the edge
    int   wlevel;
    logic wfull;
    logic wafull;
    logic wovf;
  } vec_t;

  logic                wclk;
  logic                wrst_n;
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                wen;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
`ifdef WPTR_OVF_EN
  logic                wovf_clr;
  logic                wovf;
`endif

  wptr_full_level #(
    .ADDRSIZE     (ADDRSIZE),
    .AFULL_THRESH (AFULL_THRESH)
  ) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
`ifdef WPTR_OVF_EN
    .wovf_clr (wovf_clr),
    .wovf     (wovf),
`endif
    .wen      (wen),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull),
    .wafull   (wafull),
    .wlevel   (wlevel)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t exp_q[$];

  // Reference model: plain integer write/read counts.
  int   m_w = 0;
  int   m_r = 0;
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;

  function automatic logic [ADDRSIZE:0] gray(input int b);
    logic [ADDRSIZE:0] v;
    v = b[ADDRSIZE:0];
    return v ^ (v >> 1);
  endfunction

  function automatic vec_t mk(input logic winc_i, input int rd, input logic clr,
                              input logic wen_e, input int wbin, input int lvl,
                              input logic full, input logic afull, input logic ovf);
    vec_t v;
    v.winc = winc_i; v.rd = rd; v.clr = clr; v.wen = wen_e; v.wbin = wbin;
    v.wlevel = lvl; v.wfull = full; v.wafull = afull; v.wovf = ovf;
    return v;
  endfunction

  function automatic vec_t model_exp(input logic winc_i, input int rd, input logic clr);
    vec_t v;
    int   acc;
    int   lvl;
    acc = (winc_i && !m_full) ? 1 : 0;
    lvl = m_w + acc - rd;
    v = mk(winc_i, rd, clr, acc[0], m_w + acc, lvl, lvl == DEPTH,
           lvl >= AFULL_THRESH, (winc_i && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf));
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_waddr"},  32'(waddr),  0);
    chk({tag, "_wptr"},   32'(wptr),   0);
    chk({tag, "_wlevel"}, 32'(wlevel), 0);
    chk({tag, "_wfull"},  32'(wfull),  0);
    chk({tag, "_wafull"}, 32'(wafull), 0);
`ifdef WPTR_OVF_EN
    chk({tag, "_wovf"},   32'(wovf),   0);
`endif
  endtask

  // Drive one cycle, check wen before the edge, queue the expectation and
  // compare it after the edge. The model advances alongside.
  task automatic step(input vec_t e);
    vec_t got_e;
    int   acc;
    @(negedge wclk);
    winc     = e.winc;
    wq2_rptr = gray(e.rd % (2 * DEPTH));
`ifdef WPTR_OVF_EN
    wovf_clr = e.clr;
`endif
    #1;
    chk("wen", 32'(wen), 32'(e.wen));
    exp_q.push_back(e);
    acc   = (e.winc && !m_full) ? 1 : 0;
    m_ovf = (e.winc && m_full) ? 1'b1 : (e.clr ? 1'b0 : m_ovf);
    m_w   = m_w + acc;
    m_r   = e.rd;
    m_full = ((m_w - m_r) == DEPTH);
    @(posedge wclk);
    #1;
    got_e = exp_q.pop_front();
    chk("waddr",  32'(waddr),  32'(got_e.wbin % DEPTH));
    chk("wptr",   32'(wptr),   32'(gray(got_e.wbin % (2 * DEPTH))));
    chk("wlevel", 32'(wlevel), 32'(got_e.wlevel));
    chk("wfull",  32'(wfull),  32'(got_e.wfull));
    chk("wafull", 32'(wafull), 32'(got_e.wafull));
`ifdef WPTR_OVF_EN
    chk("wovf",   32'(wovf),   32'(got_e.wovf));
`endif
    chk("full_vs_level", 32'(wfull), 32'(wlevel == (ADDRSIZE+1)'(DEPTH)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             tbl_a[17];
    vec_t             tbl_b[10];
    int               rd_d1;
    int               rd_d2;
    logic [ADDRSIZE:0] prev_wptr;

    // Fill: 16 accepted writes then a blocked 17th request.
    for (int i = 0; i < 16; i++)
      tbl_a[i] = mk(1'b1, 0, 1'b0, 1'b1, i + 1, i + 1, (i + 1) == DEPTH,
                    (i + 1) >= AFULL_THRESH, 1'b0);
    tbl_a[16] = mk(1'b1, 0, 1'b0, 1'b0, 16, 16, 1'b1, 1'b1, 1'b1);

    // Drain one while full, keep draining to 8, then write+read together.
    tbl_b[0] = mk(1'b0, 1,  1'b0, 1'b0, 16, 15, 1'b0, 1'b1, 1'b0);
    tbl_b[1] = mk(1'b0, 2,  1'b0, 1'b0, 16, 14, 1'b0, 1'b1, 1'b0);
    tbl_b[2] = mk(1'b0, 3,  1'b0, 1'b0, 16, 13, 1'b0, 1'b0, 1'b0);
    tbl_b[3] = mk(1'b0, 4,  1'b0, 1'b0, 16, 12, 1'b0, 1'b0, 1'b0);
    tbl_b[4] = mk(1'b0, 5,  1'b0, 1'b0, 16, 11, 1'b0, 1'b0, 1'b0);
    tbl_b[5] = mk(1'b0, 6,  1'b0, 1'b0, 16, 10, 1'b0, 1'b0, 1'b0);
    tbl_b[6] = mk(1'b0, 7,  1'b0, 1'b0, 16, 9,  1'b0, 1'b0, 1'b0);
    tbl_b[7] = mk(1'b0, 8,  1'b0, 1'b0, 16, 8,  1'b0, 1'b0, 1'b0);
    tbl_b[8] = mk(1'b1, 9,  1'b0, 1'b1, 17, 8,  1'b0, 1'b0, 1'b0);
    tbl_b[9] = mk(1'b1, 10, 1'b0, 1'b1, 18, 8,  1'b0, 1'b0, 1'b0);

    wrst_n   = 1'b0;
    winc     = 1'b0;
    wq2_rptr = '0;
`ifdef WPTR_OVF_EN
    wovf_clr = 1'b0;
`endif

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      winc     = 1'($urandom);
      wq2_rptr = (ADDRSIZE+1)'($urandom);
      @(posedge wclk);
      #1;
      chk_zero("rst");
      chk("rst_wen", 32'(wen), 32'(winc));
    end
    @(negedge wclk);
    wrst_n   = 1'b1;
    winc     = 1'b0;
    wq2_rptr = '0;

    for (int i = 0; i < 17; i++) step(tbl_a[i]);

`ifdef WPTR_OVF_EN
    // Two more writes while full, clear racing a write, then a lone clear.
    step(model_exp(1'b1, 0, 1'b0));
    step(model_exp(1'b1, 0, 1'b0));
    step(model_exp(1'b1, 0, 1'b1));
    step(model_exp(1'b0, 0, 1'b1));
`endif

    for (int i = 0; i < 10; i++) step(tbl_b[i]);

    // Asynchronous reset: outputs must clear without a clock edge.
    @(negedge wclk);
    winc   = 1'b1;
    wrst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge wclk);
    wrst_n   = 1'b1;
    winc     = 1'b0;
    wq2_rptr = '0;
    m_w = 0; m_r = 0; m_full = 1'b0; m_ovf = 1'b0;

    // Wrap-around: 40 writes, read pointer trailing by two cycles.
    rd_d1     = 0;
    rd_d2     = 0;
    prev_wptr = '0;
    for (int k = 0; k < 40; k++) begin
      step(model_exp(1'b1, rd_d2, 1'b0));
      chk("gray_one_bit", 32'($countones(wptr ^ prev_wptr)), 1);
      chk("wrap_level_max", 32'(wlevel <= 3), 1);
      chk("wrap_no_full", 32'(wfull), 0);
      prev_wptr = wptr;
      rd_d2 = rd_d1;
      rd_d1 = m_w;
    end

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wptr_full_level.md
# wptr_full_level

Write-clock-domain pointer and status block for the asynchronous FIFO, the parametrised successor of the basic write-pointer/full generator. It keeps the binary and Gray write pointers, raises registered full and programmable almost-full flags, and reports a registered fill level. Optionally it also reports a sticky overflow error. It sits between the write-side client and the dual-port memory, and consumes the read pointer after it has been synchronised into wclk.

## Interface
Parameters:
- ADDRSIZE, 4, memory address width; FIFO depth DEPTH = 2**ADDRSIZE; legal range is 2 or more.
- AFULL_THRESH, 2**ADDRSIZE-2, fill level at which wafull asserts; legal range 1..DEPTH.

Ports (reset wrst_n, asynchronous, active-low; clock wclk):
- wclk  in  1  write clock.
- wrst_n  in  1  asynchronous active-low reset.
- winc  in  1  write request.
- wq2_rptr  in  ADDRSIZE+1  read pointer, Gray-coded, already synchronised to wclk.
- wovf_clr  in  1  clears wovf; present only with WPTR_OVF_EN.
- wen  out  1  memory write enable, combinational: winc & ~wfull.
- waddr  out  ADDRSIZE  memory write address, equal to wbin[ADDRSIZE-1:0].
- wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchroniser.
- wfull  out  1  registered full flag.
- wafull  out  1  registered almost-full flag.
- wlevel  out  ADDRSIZE+1  registered fill level, 0..DEPTH.
- wovf  out  1  sticky overflow flag; present only with WPTR_OVF_EN.

## Operation
Registers: wbin[ADDRSIZE:0], wptr, wfull, wafull, wlevel, wovf.

Next-state logic:
- wbinnext = wbin + wen.
- wgraynext = (wbinnext >> 1) ^ wbinnext.
- rbin = Gray-to-binary of wq2_rptr (XOR prefix from the MSB down), combinational.
- level_next = (wbinnext - rbin), modulo 2**(ADDRSIZE+1).

Flag equations:
- wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}). This equation must agree with level_next == DEPTH; the bench asserts that they match.
- wafull_next = (level_next >= AFULL_THRESH).
- On every wclk edge: wbin, wptr, wfull, wafull and wlevel load their next values.

Write rules:
- A write while wfull=1 is dropped. The pointer does not move and the memory is not written.

Level behaviour:
- wlevel and the flags also update when wq2_rptr changes with no write.
- They are conservative because of the synchroniser lag: the level can read high but never low. wfull can stay asserted late but never deasserts early.

Wrap-around:
- wbin wraps from 2*DEPTH-1 to 0.
- waddr wraps from DEPTH-1 to 0.
- The Gray pointer changes exactly one bit per increment, including across the wrap.

## Timing
- Reset (async assert): wbin=0, wptr=0, wfull=0, wafull=0, wlevel=0, wovf=0. Outputs take these values immediately, without a clock edge.
- Reset deassertion is synchronous to wclk and handled externally. Reset mid-operation discards all state; the read side must be reset together with it.
- A write accepted at edge N (wen=1 before edge N) gives waddr+1, new wptr and new wlevel valid after edge N: latency 1.
- wfull asserts on the same edge that captures the DEPTH-th outstanding write, so the next cycle's winc is blocked.
- A wq2_rptr change before edge N is reflected in wfull, wafull and wlevel after edge N.
- Simultaneous write and read-pointer advance: level_next counts both, so the level stays unchanged.
- wen is combinational from winc and registered wfull. It has no path from wq2_rptr.

## Configuration
- WPTR_OVF_EN defined:
  - wovf and wovf_clr ports exist.
  - wovf sets on the edge after any cycle with winc=1 && wfull=1.
  - It holds until wovf_clr=1 is sampled.
  - If a set and wovf_clr occur in the same cycle, the set wins.
- WPTR_OVF_EN undefined:
  - Both ports and the register are absent.
  - Writes while full are dropped silently.
  - All other behaviour is identical.

## Test plan
- Reset: hold wrst_n=0 with random winc and wq2_rptr -> all outputs 0. With ADDRSIZE=4, the first post-reset write gives waddr=1, wptr=5'b00001, wlevel=1.
- Fill with ADDRSIZE=4, AFULL_THRESH=14, wq2_rptr=0, 16 back-to-back writes:
  - wafull=1 after the 14th write.
  - wfull=1 and wlevel=16 after the 16th write.
  - wen=0 on the 17th request.
- Overflow (WPTR_OVF_EN): winc=1 for 3 cycles while full:
  - waddr holds at 0 and wovf=1.
  - A wovf_clr pulse concurrent with a further full write keeps wovf=1.
  - A wovf_clr pulse with no write clears wovf to 0.
- Drain while full: step wq2_rptr Gray 0->1 -> wfull=0 and wlevel=15 one edge later; wafull stays 1.
- Simultaneous write and read advance at level 8 -> wlevel stays 8 and waddr increments.
- Wrap-around: 40 writes with wq2_rptr tracking wptr delayed by 2 cycles:
  - wbin wraps 31->0.
  - wptr changes exactly one bit per increment.
  - wlevel never exceeds 3 and wfull never asserts.
